// File: rtl/mem_bus_ctrl.sv
// Bridges the picorv32 native port to ROM/RAM/IO: decode, slave handshake, error responses.
// Latency: 2+ cycles valid-to-ready; errors after decode (2) or timeout (TIMEOUT+2); CPU stalls until ready.
module mem_bus_ctrl #(
    parameter logic [31:0] ROM_BASE = 32'h0000_0000,
    parameter logic [31:0] ROM_SIZE = 32'h0000_1000,
    parameter logic [31:0] RAM_BASE = 32'h0000_1000,
    parameter logic [31:0] RAM_SIZE = 32'h0000_1000,
    parameter logic [31:0] IO_BASE  = 32'h1000_0000,
    parameter logic [31:0] IO_SIZE  = 32'h0000_0100,
    parameter int unsigned TIMEOUT  = 15
) (
    input  logic        clk_in,
    input  logic        reset_n_in,
    input  logic        mem_valid_in,
    input  logic        mem_instr_in,
    input  logic [31:0] mem_addr_in,
    input  logic [31:0] mem_wdata_in,
    input  logic [3:0]  mem_wstrb_in,
    output logic        mem_ready_out,
    output logic [31:0] mem_rdata_out,
    output logic [29:0] slv_addr_out,
    output logic [31:0] slv_wdata_out,
    output logic [3:0]  slv_wstrb_out,
    output logic        slv_write_out,
    output logic        rom_enable_out,
    output logic        ram_enable_out,
    output logic        io_enable_out,
    input  logic        rom_ready_in,
    input  logic        ram_ready_in,
    input  logic        io_ready_in,
    input  logic [31:0] rom_rdata_in,
    input  logic [31:0] ram_rdata_in,
    input  logic [31:0] io_rdata_in,
    output logic        bus_error_out,
    output logic [31:0] err_addr_out
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2,
        S_ERROR  = 2'd3
    } state_t;

    localparam logic [7:0] LP_TIMEOUT = 8'(TIMEOUT);

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic        r_rom_en;
    logic        r_ram_en;
    logic        r_io_en;
    logic        r_mem_ready;
    logic        r_bus_error;
    logic [31:0] r_mem_rdata;
    logic [29:0] r_slv_addr;
    logic [31:0] r_slv_wdata;
    logic [3:0]  r_slv_wstrb;
    logic        r_slv_write;
    logic [31:0] r_req_addr;
    logic [31:0] r_err_addr;

    logic [31:0] w_rom_off;
    logic [31:0] w_ram_off;
    logic [31:0] w_io_off;
    logic        w_rom_hit;
    logic        w_ram_hit;
    logic        w_io_hit;
    logic        w_write;
    logic [29:0] w_slv_addr;
    logic        w_sel_rdy;
    logic [31:0] w_sel_rdata;
    logic [7:0]  w_cnt_inc;

    // Offsets wrap to huge values below a base, so one unsigned compare covers both bounds.
    assign w_rom_off = mem_addr_in - ROM_BASE;
    assign w_ram_off = mem_addr_in - RAM_BASE;
    assign w_io_off  = mem_addr_in - IO_BASE;
    assign w_rom_hit = (w_rom_off < ROM_SIZE);
    assign w_ram_hit = (w_ram_off < RAM_SIZE);
    assign w_io_hit  = (w_io_off  < IO_SIZE);
    assign w_write   = |mem_wstrb_in;

    always_comb begin
        w_slv_addr = mem_addr_in[31:2];
        if (w_rom_hit) begin
            w_slv_addr = w_rom_off[31:2];
        end else if (w_ram_hit) begin
            w_slv_addr = w_ram_off[31:2];
        end else if (w_io_hit) begin
            w_slv_addr = w_io_off[31:2];
        end
    end

    assign w_sel_rdy   = (r_rom_en & rom_ready_in) | (r_ram_en & ram_ready_in) | (r_io_en & io_ready_in);
    assign w_sel_rdata = ({32{r_rom_en}} & rom_rdata_in) |
                         ({32{r_ram_en}} & ram_rdata_in) |
                         ({32{r_io_en}}  & io_rdata_in);
    assign w_cnt_inc   = r_cnt + 8'd1;

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_state     <= S_IDLE;
            r_cnt       <= 8'd0;
            r_rom_en    <= 1'b0;
            r_ram_en    <= 1'b0;
            r_io_en     <= 1'b0;
            r_mem_ready <= 1'b0;
            r_bus_error <= 1'b0;
            r_mem_rdata <= 32'd0;
            r_slv_addr  <= 30'd0;
            r_slv_wdata <= 32'd0;
            r_slv_wstrb <= 4'd0;
            r_slv_write <= 1'b0;
            r_req_addr  <= 32'd0;
            r_err_addr  <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_mem_ready <= 1'b0;
                    r_bus_error <= 1'b0;
                    // A pending ready pulse here is an error response; the CPU has not yet dropped valid.
                    if (mem_valid_in && !r_mem_ready) begin
                        r_slv_addr  <= w_slv_addr;
                        r_slv_wdata <= mem_wdata_in;
                        r_slv_wstrb <= mem_wstrb_in;
                        r_slv_write <= w_write;
                        r_req_addr  <= mem_addr_in;
                        r_cnt       <= 8'd0;
                        if (w_rom_hit && !w_write) begin
                            r_rom_en <= 1'b1;
                            r_state  <= S_ACCESS;
                        end else if (w_ram_hit) begin
                            r_ram_en <= 1'b1;
                            r_state  <= S_ACCESS;
                        end else if (w_io_hit && !mem_instr_in) begin
                            r_io_en  <= 1'b1;
                            r_state  <= S_ACCESS;
                        end else begin
                            r_err_addr <= mem_addr_in;
                            r_state    <= S_ERROR;
                        end
                    end
                end
                S_ACCESS: begin
                    if (!mem_valid_in) begin
                        r_rom_en <= 1'b0;
                        r_ram_en <= 1'b0;
                        r_io_en  <= 1'b0;
                        r_cnt    <= 8'd0;
                        r_state  <= S_IDLE;
                    end else if (w_sel_rdy) begin
                        r_mem_rdata <= r_slv_write ? 32'd0 : w_sel_rdata;
                        r_mem_ready <= 1'b1;
                        r_rom_en    <= 1'b0;
                        r_ram_en    <= 1'b0;
                        r_io_en     <= 1'b0;
                        r_state     <= S_RESP;
                    end else if (w_cnt_inc == LP_TIMEOUT) begin
                        r_rom_en   <= 1'b0;
                        r_ram_en   <= 1'b0;
                        r_io_en    <= 1'b0;
                        r_err_addr <= r_req_addr;
                        r_state    <= S_ERROR;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                S_RESP: begin
                    r_mem_ready <= 1'b0;
                    r_cnt       <= 8'd0;
                    r_state     <= S_IDLE;
                end
                S_ERROR: begin
                    r_mem_ready <= 1'b1;
                    r_bus_error <= 1'b1;
                    r_mem_rdata <= 32'd0;
                    r_cnt       <= 8'd0;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_ready_out  = r_mem_ready;
    assign mem_rdata_out  = r_mem_rdata;
    assign slv_addr_out   = r_slv_addr;
    assign slv_wdata_out  = r_slv_wdata;
    assign slv_wstrb_out  = r_slv_wstrb;
    assign slv_write_out  = r_slv_write;
    assign rom_enable_out = r_rom_en;
    assign ram_enable_out = r_ram_en;
    assign io_enable_out  = r_io_en;
    assign bus_error_out  = r_bus_error;
    assign err_addr_out   = r_err_addr;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Bench for mem_bus_ctrl: directed scenarios plus random accesses scored against an address-map model.
module tb_mem_bus_ctrl;

    localparam logic [31:0] ROM_BASE = 32'h0000_0000;
    localparam logic [31:0] ROM_SIZE = 32'h0000_1000;
    localparam logic [31:0] RAM_BASE = 32'h0000_1000;
    localparam logic [31:0] RAM_SIZE = 32'h0000_1000;
    localparam logic [31:0] IO_BASE  = 32'h1000_0000;
    localparam logic [31:0] IO_SIZE  = 32'h0000_0100;
    localparam int          TIMEOUT  = 15;

    logic        clk_in = 1'b0;
    logic        reset_n_in;
    logic        mem_valid_in, mem_instr_in;
    logic [31:0] mem_addr_in, mem_wdata_in;
    logic [3:0]  mem_wstrb_in;
    logic        mem_ready_out;
    logic [31:0] mem_rdata_out;
    logic [29:0] slv_addr_out;
    logic [31:0] slv_wdata_out;
    logic [3:0]  slv_wstrb_out;
    logic        slv_write_out;
    logic        rom_enable_out, ram_enable_out, io_enable_out;
    logic        rom_ready_in, ram_ready_in, io_ready_in;
    logic [31:0] rom_rdata_in, ram_rdata_in, io_rdata_in;
    logic        bus_error_out;
    logic [31:0] err_addr_out;

    int          n_checks = 0;
    int          n_pass = 0;
    int          n_fail = 0;
    int          onehot_bad = 0;
    int          cfg_lat = 1;
    bit          cfg_noise = 1'b0;
    logic [31:0] exp_err;

    mem_bus_ctrl dut (
        .clk_in(clk_in), .reset_n_in(reset_n_in),
        .mem_valid_in(mem_valid_in), .mem_instr_in(mem_instr_in),
        .mem_addr_in(mem_addr_in), .mem_wdata_in(mem_wdata_in), .mem_wstrb_in(mem_wstrb_in),
        .mem_ready_out(mem_ready_out), .mem_rdata_out(mem_rdata_out),
        .slv_addr_out(slv_addr_out), .slv_wdata_out(slv_wdata_out),
        .slv_wstrb_out(slv_wstrb_out), .slv_write_out(slv_write_out),
        .rom_enable_out(rom_enable_out), .ram_enable_out(ram_enable_out), .io_enable_out(io_enable_out),
        .rom_ready_in(rom_ready_in), .ram_ready_in(ram_ready_in), .io_ready_in(io_ready_in),
        .rom_rdata_in(rom_rdata_in), .ram_rdata_in(ram_rdata_in), .io_rdata_in(io_rdata_in),
        .bus_error_out(bus_error_out), .err_addr_out(err_addr_out)
    );

    initial forever #20 clk_in = ~clk_in;

    // Slave models: ready rises after cfg_lat enabled cycles (0 = never); unselected slaves may chatter.
    initial begin
        int cnt[3];
        bit en[3];
        bit rdy[3];
        for (int s = 0; s < 3; s++) cnt[s] = 0;
        rom_ready_in = 1'b0; ram_ready_in = 1'b0; io_ready_in = 1'b0;
        forever begin
            @(negedge clk_in);
            en[0] = rom_enable_out; en[1] = ram_enable_out; en[2] = io_enable_out;
            if (int'(en[0]) + int'(en[1]) + int'(en[2]) > 1) onehot_bad++;
            for (int s = 0; s < 3; s++) begin
                if (en[s]) cnt[s]++; else cnt[s] = 0;
                rdy[s] = en[s] ? (cfg_lat != 0 && cnt[s] >= cfg_lat)
                               : (cfg_noise && $urandom_range(0, 1) == 1);
            end
            rom_ready_in = rdy[0]; ram_ready_in = rdy[1]; io_ready_in = rdy[2];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic bit in_rng(input logic [31:0] a, input logic [31:0] b, input logic [31:0] sz);
        longint unsigned la, lb, ls;
        la = {32'd0, a}; lb = {32'd0, b}; ls = {32'd0, sz};
        return (la >= lb) && (la < lb + ls);
    endfunction

    // 0 = error, 1 = ROM, 2 = RAM, 3 = IO
    function automatic int model_target(input logic [31:0] a, input logic instr, input logic [3:0] ws);
        if (in_rng(a, ROM_BASE, ROM_SIZE)) return (ws == 4'd0) ? 1 : 0;
        if (in_rng(a, RAM_BASE, RAM_SIZE)) return 2;
        if (in_rng(a, IO_BASE, IO_SIZE)) return instr ? 0 : 3;
        return 0;
    endfunction

    function automatic logic [31:0] model_offset(input logic [31:0] a);
        if (in_rng(a, ROM_BASE, ROM_SIZE)) return (a - ROM_BASE) / 4;
        if (in_rng(a, RAM_BASE, RAM_SIZE)) return (a - RAM_BASE) / 4;
        return (a - IO_BASE) / 4;
    endfunction

    function automatic logic [31:0] pick_addr();
        case ($urandom_range(0, 9))
            0:       return ROM_BASE + 4 * $urandom_range(0, 1023);
            1:       return ROM_BASE + ROM_SIZE - 4;
            2, 3:    return RAM_BASE + 4 * $urandom_range(0, 1023);
            4:       return RAM_BASE + RAM_SIZE - 4;
            5:       return RAM_BASE + RAM_SIZE;
            6:       return IO_BASE + 4 * $urandom_range(0, 63);
            7:       return IO_BASE + IO_SIZE;
            8:       return IO_BASE - 4;
            default: return $urandom;
        endcase
    endfunction

    function automatic bit any_en();
        return rom_enable_out | ram_enable_out | io_enable_out;
    endfunction

    task automatic do_txn(input logic [31:0] addr, input logic instr, input logic [3:0] wstrb,
                          input logic [31:0] wdata, input int lat, input logic [31:0] rdv,
                          input bit noise, input string tag);
        int          tgt, cyc, spur, en_tgt, en_all;
        int          ecnt[3];
        bit          got, cap;
        logic [31:0] rd, ea;
        logic        be, sw;
        logic [29:0] sa;
        logic [3:0]  ss;
        logic [31:0] swd;
        logic [31:0] rds[3];
        tgt = model_target(addr, instr, wstrb);
        for (int s = 0; s < 3; s++) rds[s] = $urandom;
        if (tgt != 0) rds[tgt - 1] = rdv;
        rom_rdata_in = rds[0]; ram_rdata_in = rds[1]; io_rdata_in = rds[2];
        cfg_lat = lat; cfg_noise = noise;
        mem_valid_in = 1'b1; mem_instr_in = instr; mem_addr_in = addr;
        mem_wdata_in = wdata; mem_wstrb_in = wstrb;
        for (int s = 0; s < 3; s++) ecnt[s] = 0;
        cyc = 0; got = 0; cap = 0;
        while (!got && cyc < 100) begin
            @(posedge clk_in); @(negedge clk_in); cyc++;
            if (rom_enable_out) ecnt[0]++;
            if (ram_enable_out) ecnt[1]++;
            if (io_enable_out)  ecnt[2]++;
            if (!cap && any_en()) begin
                cap = 1; sa = slv_addr_out; sw = slv_write_out; ss = slv_wstrb_out; swd = slv_wdata_out;
            end
            if (mem_ready_out) begin
                got = 1; rd = mem_rdata_out; be = bus_error_out; ea = err_addr_out;
            end
        end
        // valid stays high across the edge that closes the response cycle
        spur = 0;
        @(posedge clk_in); @(negedge clk_in);
        if (mem_ready_out || any_en()) spur++;
        mem_valid_in = 1'b0; mem_wstrb_in = 4'd0; cfg_noise = 1'b0;
        repeat (2) begin
            @(posedge clk_in); @(negedge clk_in);
            if (mem_ready_out || any_en()) spur++;
        end
        en_all = ecnt[0] + ecnt[1] + ecnt[2];
        en_tgt = (tgt != 0) ? ecnt[tgt - 1] : 0;
        if (tgt == 0 || lat == 0) exp_err = addr;
        chk({tag, ".resp"}, 32'(got), 32'd1);
        if (tgt == 0) begin
            chk({tag, ".en_cycles"}, 32'(en_all), 32'd0);
            chk({tag, ".latency"}, 32'(cyc), 32'd2);
            chk({tag, ".bus_err"}, 32'(be), 32'd1);
            chk({tag, ".rdata"}, rd, 32'd0);
        end else if (lat == 0) begin
            chk({tag, ".en_cycles"}, 32'(en_tgt), 32'(TIMEOUT));
            chk({tag, ".en_other"}, 32'(en_all - en_tgt), 32'd0);
            chk({tag, ".latency"}, 32'(cyc), 32'(TIMEOUT + 2));
            chk({tag, ".bus_err"}, 32'(be), 32'd1);
            chk({tag, ".rdata"}, rd, 32'd0);
        end else begin
            chk({tag, ".en_cycles"}, 32'(en_tgt), 32'(lat));
            chk({tag, ".en_other"}, 32'(en_all - en_tgt), 32'd0);
            chk({tag, ".latency"}, 32'(cyc), 32'(lat + 1));
            chk({tag, ".bus_err"}, 32'(be), 32'd0);
            chk({tag, ".rdata"}, rd, (wstrb != 4'd0) ? 32'd0 : rdv);
            chk({tag, ".slv_addr"}, {2'b00, sa}, model_offset(addr));
            chk({tag, ".slv_write"}, 32'(sw), 32'(wstrb != 4'd0));
            chk({tag, ".slv_wstrb"}, 32'(ss), 32'(wstrb));
            chk({tag, ".slv_wdata"}, swd, wdata);
        end
        chk({tag, ".err_addr"}, ea, exp_err);
        chk({tag, ".no_reaccept"}, 32'(spur), 32'd0);
    endtask

    initial begin
        int spur;
        reset_n_in = 1'b0; mem_valid_in = 1'b0; mem_instr_in = 1'b0;
        mem_addr_in = 32'd0; mem_wdata_in = 32'd0; mem_wstrb_in = 4'd0;
        rom_rdata_in = 32'd0; ram_rdata_in = 32'd0; io_rdata_in = 32'd0;
        exp_err = 32'd0;

        #5;
        chk("rst.ready", 32'(mem_ready_out), 32'd0);
        chk("rst.bus_err", 32'(bus_error_out), 32'd0);
        chk("rst.enables", 32'({rom_enable_out, ram_enable_out, io_enable_out}), 32'd0);
        chk("rst.rdata", mem_rdata_out, 32'd0);
        chk("rst.slv_addr", {2'b00, slv_addr_out}, 32'd0);
        chk("rst.slv_wdata", slv_wdata_out, 32'd0);
        chk("rst.wstrb_write", 32'({slv_wstrb_out, slv_write_out}), 32'd0);
        chk("rst.err_addr", err_addr_out, 32'd0);
        repeat (2) @(negedge clk_in);
        reset_n_in = 1'b1;
        @(negedge clk_in);

        do_txn(32'h0000_0010, 1'b1, 4'b0000, 32'd0, 1, 32'hDEAD_BEEF, 1'b0, "rom_fetch");
        do_txn(32'h0000_1004, 1'b0, 4'b0011, 32'h1234_5678, 3, 32'hCAFE_F00D, 1'b0, "ram_write");
        do_txn(32'h0000_0020, 1'b0, 4'b1111, 32'h5555_AAAA, 1, 32'd0, 1'b0, "rom_wr_err");
        do_txn(32'h0000_3000, 1'b0, 4'b0000, 32'd0, 1, 32'd0, 1'b0, "unmapped");
        do_txn(32'h1000_0000, 1'b1, 4'b0000, 32'd0, 1, 32'd0, 1'b0, "io_fetch_err");
        chk("err_addr_final", err_addr_out, 32'h1000_0000);
        do_txn(32'h1000_0004, 1'b0, 4'b0000, 32'd0, 0, 32'd0, 1'b1, "io_timeout");
        do_txn(32'h0000_1FFC, 1'b0, 4'b0000, 32'd0, 2, 32'h0BAD_CAFE, 1'b1, "ram_after_to");

        // CPU withdraws valid mid-access: transfer abandoned, no ready
        cfg_lat = 0;
        mem_valid_in = 1'b1; mem_instr_in = 1'b0; mem_addr_in = 32'h0000_1008; mem_wstrb_in = 4'd0;
        repeat (4) begin @(posedge clk_in); @(negedge clk_in); end
        chk("abort.en_before", 32'(ram_enable_out), 32'd1);
        mem_valid_in = 1'b0;
        @(posedge clk_in); @(negedge clk_in);
        chk("abort.en_after", 32'(any_en()), 32'd0);
        spur = 0;
        repeat (20) begin
            @(posedge clk_in); @(negedge clk_in);
            if (mem_ready_out || any_en()) spur++;
        end
        chk("abort.no_ready", 32'(spur), 32'd0);
        chk("abort.err_addr", err_addr_out, exp_err);

        // Reset in the middle of a RAM access
        cfg_lat = 0;
        mem_valid_in = 1'b1; mem_addr_in = 32'h0000_1010;
        repeat (3) begin @(posedge clk_in); @(negedge clk_in); end
        chk("midrst.en_before", 32'(ram_enable_out), 32'd1);
        #5 reset_n_in = 1'b0;
        #1;
        chk("midrst.enables", 32'({rom_enable_out, ram_enable_out, io_enable_out}), 32'd0);
        chk("midrst.ready", 32'(mem_ready_out), 32'd0);
        chk("midrst.err_addr", err_addr_out, 32'd0);
        exp_err = 32'd0;
        mem_valid_in = 1'b0;
        @(negedge clk_in);
        reset_n_in = 1'b1;
        spur = 0;
        repeat (4) begin
            @(posedge clk_in); @(negedge clk_in);
            if (mem_ready_out || any_en()) spur++;
        end
        chk("midrst.no_pulse", 32'(spur), 32'd0);
        do_txn(32'h0000_0040, 1'b1, 4'b0000, 32'd0, 1, 32'h0102_0304, 1'b0, "rom_after_rst");

        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            logic [3:0]  ws;
            int          lat;
            a   = pick_addr();
            ws  = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'd0;
            lat = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 4));
            do_txn(a, 1'($urandom_range(0, 1)), ws, $urandom, lat, $urandom,
                   1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
        end

        chk("onehot_violations", 32'(onehot_bad), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_bus_ctrl.md
Name: mem_bus_ctrl

Overview:
- Controller between the picorv32 native memory port and the three on-chip slaves: ROM (0x0000_0000), RAM (0x0000_1000) and IO registers (0x1000_0000).
- Decodes each CPU request and enables exactly one slave.
- Sequences the slave handshake, returns registered read data and ready to the CPU.
- Turns illegal, unmapped or hung accesses into a clean error response, so the CPU never stalls forever.

Parameters:
ROM_BASE, 32'h0000_0000, ROM region base (byte address, SIZE-aligned)
ROM_SIZE, 32'h0000_1000, ROM region size in bytes (power of two)
RAM_BASE, 32'h0000_1000, RAM region base
RAM_SIZE, 32'h0000_1000, RAM region size in bytes
IO_BASE, 32'h1000_0000, IO region base
IO_SIZE, 32'h0000_0100, IO region size in bytes
TIMEOUT, 15, max cycles waiting for slave ready before error (1..255)

Ports:
clk_in  input  1  system clock (25 MHz)
reset_n_in  input  1  asynchronous active-low reset
mem_valid_in  input  1  CPU request valid
mem_instr_in  input  1  request is instruction fetch
mem_addr_in  input  32  CPU byte address
mem_wdata_in  input  32  CPU write data
mem_wstrb_in  input  4  byte write strobes; nonzero = write
mem_ready_out  output  1  one-cycle completion pulse to CPU
mem_rdata_out  output  32  registered read data to CPU
slv_addr_out  output  30  word offset within selected region: (addr - base) >> 2
slv_wdata_out  output  32  write data to slaves
slv_wstrb_out  output  4  strobes to slaves
slv_write_out  output  1  1 = write access
rom_enable_out / ram_enable_out / io_enable_out  output  1 each  slave selects
rom_ready_in / ram_ready_in / io_ready_in  input  1 each  slave done
rom_rdata_in / ram_rdata_in / io_rdata_in  input  32 each  slave read data
bus_error_out  output  1  one-cycle pulse on error response
err_addr_out  output  32  address of most recent errored access

Behaviour:
- Reset (async, reset_n_in low):
  - FSM goes to IDLE.
  - All enables, mem_ready_out, bus_error_out, slv_write_out go to 0.
  - mem_rdata_out, slv_addr_out, slv_wdata_out, slv_wstrb_out, err_addr_out go to 0.
  - Timeout counter goes to 0.
  - Reset mid-access abandons the transfer with no ready pulse.
- FSM states: IDLE, ACCESS, RESP, ERROR.
- IDLE: when mem_valid_in=1, decode and latch addr/wdata/wstrb/write into the slv_* registers.
  - Hit is base <= addr < base+size.
  - ROM hit with wstrb=0: ROM, go to ACCESS.
  - ROM hit with wstrb!=0: error.
  - RAM hit: RAM, read or write, instr allowed, go to ACCESS.
  - IO hit with mem_instr_in=0: IO, go to ACCESS.
  - IO hit with mem_instr_in=1: error.
  - No hit: error.
  - Error: latch err_addr_out <= mem_addr_in, go to ERROR.
- ACCESS:
  - Exactly one selected enable is high; counter increments each cycle.
  - Selected ready=1: mem_rdata_out <= selected rdata (0 on writes), drop enable, go to RESP.
  - Ready of unselected slaves is ignored.
  - Counter reaches TIMEOUT without ready: drop enable, latch err_addr_out, go to ERROR.
  - If ready and timeout coincide, ready wins.
  - mem_valid_in falling in ACCESS (protocol violation): drop enable, return to IDLE, no ready pulse.
- RESP: mem_ready_out=1 for exactly this cycle; clear counter; go to IDLE.
- ERROR: mem_ready_out=1 and bus_error_out=1 for exactly this cycle, mem_rdata_out=0; go to IDLE.
- IDLE is always entered for at least one cycle after a response, so a still-high mem_valid_in is not re-accepted in the ready cycle.
- Latency:
  - valid sampled at edge 0, enable high after edge 0.
  - Slave ready sampled at edge k gives mem_ready_out high after edge k.
  - Minimum 2 cycles valid-to-ready with a slave that responds the cycle after enable.
  - Error latency is 2 cycles for decode errors and TIMEOUT+2 cycles for timeouts.
- Widths: region compares are unsigned 32-bit; the subtraction is 32-bit, bits [31:2] go to slv_addr_out; upper bits are zero by construction.
- Enables are one-hot or all-zero at all times.

Test Plan:
- ROM fetch addr 0x0000_0010, instr=1, rom_ready one cycle after enable, rom_rdata=0xDEADBEEF -> rom_enable only, slv_addr_out=4, mem_ready_out one-cycle pulse with mem_rdata_out=0xDEADBEEF, bus_error_out=0.
- RAM write addr 0x0000_1004, wstrb=4'b0011, wdata=0x1234_5678, ram_ready after 3 cycles -> ram_enable held 3 cycles, slv_addr_out=1, slv_write_out=1, slv_wstrb_out=0011, single ready pulse, mem_rdata_out=0.
- Write to ROM addr 0x0000_0020 wstrb=4'b1111 -> no enable ever high, ready+bus_error_out pulse together 2 cycles after valid, err_addr_out=0x0000_0020, mem_rdata_out=0.
- Unmapped read 0x0000_3000, then instr fetch 0x1000_0000 -> both error, err_addr_out ends as 0x1000_0000, io_enable_out never high.
- IO read 0x1000_0004 with io_ready stuck 0 -> io_enable high exactly 15 cycles, then error pulse, err_addr_out=0x1000_0004; next RAM read completes normally.
- Assert reset_n_in low during RAM ACCESS -> all enables and mem_ready_out 0 immediately, no pulse after release, next ROM fetch succeeds.
